// File: rtl/frog_collision_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : frog_collision_ctrl_pkg
// Brief    : Shared state encoding and field widths for the collision controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package frog_collision_ctrl_pkg;

    localparam int c_COORD_W = 10;
    localparam int c_LIVES_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SCAN      = 2'd1,
        ST_RESPAWN   = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/frog_collision_ctrl_box_overlap.sv
//------------------------------------------------------------------------------
// Module   : box_overlap
// Brief    : Combinational strict-overlap test of two axis-aligned boxes.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module box_overlap
    import frog_collision_ctrl_pkg::*;
#(
    parameter int c_A_WIDTH  = 32,
    parameter int c_A_HEIGHT = 32,
    parameter int c_B_WIDTH  = 32,
    parameter int c_B_HEIGHT = 32
) (
    input  logic [c_COORD_W-1:0] i_A_X,
    input  logic [c_COORD_W-1:0] i_A_Y,
    input  logic [c_COORD_W-1:0] i_B_X,
    input  logic [c_COORD_W-1:0] i_B_Y,
    output logic                 o_Overlap
);

    // One extra bit so that edge + size can never wrap.
    logic [c_COORD_W:0] a_x_ext;
    logic [c_COORD_W:0] a_y_ext;
    logic [c_COORD_W:0] b_x_ext;
    logic [c_COORD_W:0] b_y_ext;

    always_comb begin
        a_x_ext   = {1'b0, i_A_X};
        a_y_ext   = {1'b0, i_A_Y};
        b_x_ext   = {1'b0, i_B_X};
        b_y_ext   = {1'b0, i_B_Y};
        o_Overlap = (a_x_ext < b_x_ext + (c_COORD_W+1)'(c_B_WIDTH))  &&
                    (b_x_ext < a_x_ext + (c_COORD_W+1)'(c_A_WIDTH))  &&
                    (a_y_ext < b_y_ext + (c_COORD_W+1)'(c_B_HEIGHT)) &&
                    (b_y_ext < a_y_ext + (c_COORD_W+1)'(c_A_HEIGHT));
    end

endmodule

`default_nettype wire

// File: rtl/frog_collision_ctrl.sv
//------------------------------------------------------------------------------
// Module   : frog_collision_ctrl
// Brief    : Round-robin car/frog collision scan with lives, respawn hold and
//            sticky game-over.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module frog_collision_ctrl
    import frog_collision_ctrl_pkg::*;
#(
    parameter int c_NUM_CARS       = 4,
    parameter int c_CAR_WIDTH      = 32,
    parameter int c_CAR_HEIGHT     = 32,
    parameter int c_FROG_WIDTH     = 32,
    parameter int c_FROG_HEIGHT    = 32,
    parameter int c_LIVES          = 3,
    parameter int c_RESPAWN_CYCLES = 25000000
) (
    input  logic                            i_Clk,
    input  logic                            i_Rst,
    input  logic                            i_Game_Active,
    input  logic [c_COORD_W-1:0]            i_Frog_X,
    input  logic [c_COORD_W-1:0]            i_Frog_Y,
    input  logic [c_COORD_W*c_NUM_CARS-1:0] i_Cars_X,
    input  logic [c_COORD_W*c_NUM_CARS-1:0] i_Cars_Y,
    output logic                            o_Hit,
    output logic                            o_Respawn,
    output logic [c_LIVES_W-1:0]            o_Lives,
    output logic                            o_Game_Over
);

    localparam int c_IDX_W = (c_NUM_CARS > 1) ? $clog2(c_NUM_CARS) : 1;
    localparam int c_CNT_W = $clog2(c_RESPAWN_CYCLES);
    localparam logic [c_IDX_W-1:0]   c_LAST_IDX  = c_IDX_W'(c_NUM_CARS - 1);
    localparam logic [c_CNT_W-1:0]   c_CNT_LOAD  = c_CNT_W'(c_RESPAWN_CYCLES - 1);
    localparam logic [c_LIVES_W-1:0] c_LIVES_INI = c_LIVES_W'(c_LIVES);

    state_t               state_q, state_d;
    logic [c_IDX_W-1:0]   idx_q, idx_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic [c_LIVES_W-1:0] lives_q, lives_d;
    logic                 hit_q, hit_d;
    logic                 respawn_q, respawn_d;
    logic                 game_over_q, game_over_d;
    logic                 active_q, active_d;

    logic [c_COORD_W-1:0] car_x;
    logic [c_COORD_W-1:0] car_y;
    logic                 overlap;

    always_comb begin
        car_x = '0;
        car_y = '0;
        for (int k = 0; k < c_NUM_CARS; k++) begin
            if (idx_q == c_IDX_W'(k)) begin
                car_x = i_Cars_X[k*c_COORD_W +: c_COORD_W];
                car_y = i_Cars_Y[k*c_COORD_W +: c_COORD_W];
            end
        end
    end

    box_overlap #(
        .c_A_WIDTH  (c_FROG_WIDTH),
        .c_A_HEIGHT (c_FROG_HEIGHT),
        .c_B_WIDTH  (c_CAR_WIDTH),
        .c_B_HEIGHT (c_CAR_HEIGHT)
    ) u_box_overlap (
        .i_A_X     (i_Frog_X),
        .i_A_Y     (i_Frog_Y),
        .i_B_X     (car_x),
        .i_B_Y     (car_y),
        .o_Overlap (overlap)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        lives_d     = lives_q;
        hit_d       = 1'b0;
        respawn_d   = 1'b0;
        game_over_d = game_over_q;
        active_d    = i_Game_Active;

        unique case (state_q)
            ST_IDLE: begin
                lives_d     = c_LIVES_INI;
                game_over_d = 1'b0;
                idx_d       = '0;
                cnt_d       = '0;
                if (i_Game_Active) begin
                    state_d = ST_SCAN;
                end
            end

            // Losing the enable outranks a hit found in the same cycle.
            ST_SCAN: begin
                if (!i_Game_Active) begin
                    state_d = ST_IDLE;
                    lives_d = c_LIVES_INI;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (overlap) begin
                    hit_d   = 1'b1;
                    lives_d = lives_q - 1'b1;
                    idx_d   = '0;
                    if (lives_q > 1) begin
                        respawn_d = 1'b1;
                        cnt_d     = c_CNT_LOAD;
                        state_d   = ST_RESPAWN;
                    end else begin
                        game_over_d = 1'b1;
                        state_d     = ST_GAME_OVER;
                    end
                end else begin
                    idx_d = (idx_q == c_LAST_IDX) ? '0 : idx_q + 1'b1;
                end
            end

            ST_RESPAWN: begin
                if (!i_Game_Active) begin
                    state_d = ST_IDLE;
                    lives_d = c_LIVES_INI;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            // Only a fresh rising edge of the enable restarts the game.
            ST_GAME_OVER: begin
                lives_d = '0;
                if (i_Game_Active && !active_q) begin
                    state_d     = ST_SCAN;
                    lives_d     = c_LIVES_INI;
                    game_over_d = 1'b0;
                    idx_d       = '0;
                    cnt_d       = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            lives_q     <= c_LIVES_INI;
            hit_q       <= 1'b0;
            respawn_q   <= 1'b0;
            game_over_q <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            lives_q     <= lives_d;
            hit_q       <= hit_d;
            respawn_q   <= respawn_d;
            game_over_q <= game_over_d;
            active_q    <= active_d;
        end
    end

    assign o_Hit       = hit_q;
    assign o_Respawn   = respawn_q;
    assign o_Lives     = lives_q;
    assign o_Game_Over = game_over_q;

endmodule

`default_nettype wire
